// File: rtl/branch_update_ctrl_if.sv
// ============================================================================
// Module      : branch_update_ctrl_if
// Description : Prediction, resolution, predictor-update and redirect bundle
//               for branch_update_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_update_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [IDX_W-1:0] pred_idx;
    logic             alloc_ready;

    logic             res_valid;
    logic             res_taken;
    logic [31:0]      res_target;
    logic             res_ready;

    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic [31:0]      upd_tag;
    logic [31:0]      upd_target;
    logic             upd_taken;
    logic             upd_ready;

    logic             flush;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] occupancy;
    logic [15:0]      mispredict_cnt;
    logic             err_underflow;

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_target, pred_idx,
        output alloc_ready,
        input  res_valid, res_taken, res_target,
        output res_ready,
        output upd_valid, upd_index, upd_tag, upd_target, upd_taken,
        input  upd_ready,
        output flush, redirect_pc, occupancy, mispredict_cnt, err_underflow
    );

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_target, pred_idx,
        input  alloc_ready,
        output res_valid, res_taken, res_target,
        input  res_ready,
        input  upd_valid, upd_index, upd_tag, upd_target, upd_taken,
        output upd_ready,
        input  flush, redirect_pc, occupancy, mispredict_cnt, err_underflow
    );
endinterface

`default_nettype wire

// File: rtl/branch_update_ctrl.sv
// ============================================================================
// Module      : branch_update_ctrl
// Description : In-order in-flight branch queue; turns resolutions into
//               predictor updates and mispredict flush/redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_update_ctrl #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_update_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_UPD  = 1'b1;

    logic [31:0]      pc_mem     [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [31:0]      target_mem [DEPTH];
    logic [IDX_W-1:0] idx_mem    [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] upd_index_q, upd_index_d;
    logic [31:0]      upd_tag_q, upd_tag_d;
    logic [31:0]      upd_target_q, upd_target_d;
    logic             upd_taken_q, upd_taken_d;
    logic             flush_q, flush_d;
    logic [31:0]      redirect_q, redirect_d;
    logic [15:0]      mcnt_q, mcnt_d;
    logic             err_q, err_d;

    logic             w_alloc_ready;
    logic             w_res_ready;
    logic             w_accept;
    logic             w_mispredict;
    logic             w_alloc;
    logic [31:0]      w_head_pc;
    logic             w_head_taken;
    logic [31:0]      w_head_target;
    logic [IDX_W-1:0] w_head_idx;

    assign w_head_pc     = pc_mem[head_q];
    assign w_head_taken  = taken_mem[head_q];
    assign w_head_target = target_mem[head_q];
    assign w_head_idx    = idx_mem[head_q];

    assign w_alloc_ready = (count_q != C_FULL);
    assign w_res_ready   = (state_q == S_IDLE) || bus.upd_ready;
    assign w_accept      = bus.res_valid && w_res_ready && (count_q != '0);
    assign w_mispredict  = w_accept &&
                           ((w_head_taken != bus.res_taken) ||
                            (bus.res_taken && (w_head_target != bus.res_target)));
    // A mispredict squashes the younger path, so its same-cycle allocation is dropped.
    assign w_alloc       = bus.pred_valid && w_alloc_ready && !w_mispredict;

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        state_d      = state_q;
        upd_index_d  = upd_index_q;
        upd_tag_d    = upd_tag_q;
        upd_target_d = upd_target_q;
        upd_taken_d  = upd_taken_q;
        flush_d      = w_mispredict;
        redirect_d   = redirect_q;
        mcnt_d       = mcnt_q;
        err_d        = err_q || (bus.res_valid && (count_q == '0));

        if (w_alloc) begin
            tail_d  = tail_q + PTR_W'(1);
            count_d = count_d + CNT_W'(1);
        end
        if (w_accept) begin
            head_d       = head_q + PTR_W'(1);
            count_d      = count_d - CNT_W'(1);
            state_d      = S_UPD;
            upd_index_d  = w_head_idx;
            upd_tag_d    = w_head_pc;
            upd_target_d = bus.res_target;
            upd_taken_d  = bus.res_taken;
        end else if ((state_q == S_UPD) && bus.upd_ready) begin
            state_d = S_IDLE;
        end
        if (w_mispredict) begin
            head_d     = tail_q;
            count_d    = '0;
            redirect_d = bus.res_taken ? bus.res_target : (w_head_pc + 32'd4);
            if (mcnt_q != 16'hFFFF) begin
                mcnt_d = mcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            upd_index_q  <= '0;
            upd_tag_q    <= '0;
            upd_target_q <= '0;
            upd_taken_q  <= 1'b0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            mcnt_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            upd_index_q  <= upd_index_d;
            upd_tag_q    <= upd_tag_d;
            upd_target_q <= upd_target_d;
            upd_taken_q  <= upd_taken_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            mcnt_q       <= mcnt_d;
            err_q        <= err_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_alloc && !reset) begin
            pc_mem[tail_q]     <= bus.pred_pc;
            taken_mem[tail_q]  <= bus.pred_taken;
            target_mem[tail_q] <= bus.pred_target;
            idx_mem[tail_q]    <= bus.pred_idx;
        end
    end

    assign bus.alloc_ready    = w_alloc_ready;
    assign bus.res_ready      = w_res_ready;
    assign bus.upd_valid      = (state_q == S_UPD);
    assign bus.upd_index      = upd_index_q;
    assign bus.upd_tag        = upd_tag_q;
    assign bus.upd_target     = upd_target_q;
    assign bus.upd_taken      = upd_taken_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_pc    = redirect_q;
    assign bus.occupancy      = count_q;
    assign bus.mispredict_cnt = mcnt_q;
    assign bus.err_underflow  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_update_ctrl.sv
// ============================================================================
// Module      : tb_branch_update_ctrl
// Description : Self-checking bench for branch_update_ctrl against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_update_ctrl;
    localparam int DEPTH = 4;
    localparam int IDX_W = 5;

    typedef struct {
        logic [31:0]      pc;
        logic             taken;
        logic [31:0]      target;
        logic [IDX_W-1:0] idx;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_update_ctrl_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();
    branch_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errs = 0;
    int checks = 0;

    ent_t             q[$];
    logic             m_uv;
    logic [IDX_W-1:0] m_idx;
    logic [31:0]      m_tag, m_target, m_redirect;
    logic             m_taken, m_flush, m_err;
    logic [15:0]      m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_uv = 0; m_idx = '0; m_tag = '0; m_target = '0; m_taken = 0;
        m_flush = 0; m_redirect = '0; m_cnt = '0; m_err = 0;
    endtask

    task automatic check_all();
        chk("alloc_ready", 32'(bus.alloc_ready), 32'(q.size() != DEPTH));
        chk("res_ready", 32'(bus.res_ready), 32'(!m_uv || bus.upd_ready));
        chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
        chk("upd_valid", 32'(bus.upd_valid), 32'(m_uv));
        chk("upd_index", 32'(bus.upd_index), 32'(m_idx));
        chk("upd_tag", bus.upd_tag, m_tag);
        chk("upd_target", bus.upd_target, m_target);
        chk("upd_taken", 32'(bus.upd_taken), 32'(m_taken));
        chk("flush", 32'(bus.flush), 32'(m_flush));
        chk("redirect_pc", bus.redirect_pc, m_redirect);
        chk("mispredict_cnt", 32'(bus.mispredict_cnt), 32'(m_cnt));
        chk("err_underflow", 32'(bus.err_underflow), 32'(m_err));
    endtask

    // Model advances one clock edge from the inputs currently driven.
    task automatic model_step();
        bit   can_alloc, accept, mis;
        ent_t h, n;
        if (reset) begin
            model_clear();
            return;
        end
        can_alloc = bus.pred_valid && (q.size() != DEPTH);
        accept    = bus.res_valid && (!m_uv || bus.upd_ready) && (q.size() != 0);
        if (bus.res_valid && q.size() == 0) m_err = 1;
        mis = 0;
        if (accept) begin
            h = q.pop_front();
            mis = (h.taken != bus.res_taken) || (bus.res_taken && h.target != bus.res_target);
            m_uv = 1; m_idx = h.idx; m_tag = h.pc;
            m_target = bus.res_target; m_taken = bus.res_taken;
        end else if (bus.upd_ready) begin
            m_uv = 0;
        end
        m_flush = mis;
        if (mis) begin
            m_redirect = bus.res_taken ? bus.res_target : h.pc + 32'd4;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            q.delete();
        end else if (can_alloc) begin
            n.pc = bus.pred_pc; n.taken = bus.pred_taken;
            n.target = bus.pred_target; n.idx = bus.pred_idx;
            q.push_back(n);
        end
    endtask

    // Called at a falling edge: drive, compare, advance model, wait next falling edge.
    task automatic cyc(input logic pv, input logic [31:0] pc, input logic pt,
                       input logic [31:0] ptg, input logic [IDX_W-1:0] pidx,
                       input logic rv, input logic rt, input logic [31:0] rtg,
                       input logic ur, input logic rs);
        reset = rs;
        bus.pred_valid = pv; bus.pred_pc = pc; bus.pred_taken = pt;
        bus.pred_target = ptg; bus.pred_idx = pidx;
        bus.res_valid = rv; bus.res_taken = rt; bus.res_target = rtg;
        bus.upd_ready = ur;
        #1;
        check_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input logic ur);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, ur, 0);
    endtask

    initial begin
        logic        rs, pv, pt, rv, rt, ur;
        logic [31:0] pc, ptg, rtg;
        logic [IDX_W-1:0] pidx;

        model_clear();
        reset = 1;
        bus.pred_valid = 0; bus.pred_pc = 0; bus.pred_taken = 0;
        bus.pred_target = 0; bus.pred_idx = 0;
        bus.res_valid = 0; bus.res_taken = 0; bus.res_target = 0; bus.upd_ready = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);

        // Correct prediction produces an update, no flush
        cyc(1, 32'h100, 1, 32'h200, 5'd3, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h200, 1, 0);
        chk("d1_upd_valid", 32'(bus.upd_valid), 32'd1);
        chk("d1_upd_index", 32'(bus.upd_index), 32'd3);
        chk("d1_upd_tag", bus.upd_tag, 32'h100);
        chk("d1_upd_target", bus.upd_target, 32'h200);
        chk("d1_flush", 32'(bus.flush), 32'd0);
        idle(1);

        // Direction mispredict
        cyc(1, 32'h40, 0, 32'h44, 5'd1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h80, 1, 0);
        chk("d2_flush", 32'(bus.flush), 32'd1);
        chk("d2_redirect", bus.redirect_pc, 32'h80);
        chk("d2_occupancy", 32'(bus.occupancy), 32'd0);
        chk("d2_mcnt", 32'(bus.mispredict_cnt), 32'd1);
        idle(1);
        chk("d2_flush_one_cycle", 32'(bus.flush), 32'd0);
        chk("d2_redirect_hold", bus.redirect_pc, 32'h80);

        // Fill, overflow attempt, then drain in order across the pointer wrap
        for (int i = 0; i < 4; i++)
            cyc(1, 32'h1000 + 32'(i * 4), 0, 0, 5'(i), 0, 0, 0, 1, 0);
        chk("d3_full", 32'(bus.alloc_ready), 32'd0);
        cyc(1, 32'h2000, 0, 0, 5'd9, 0, 0, 0, 1, 0);
        chk("d3_drop", 32'(bus.occupancy), 32'd4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
            chk("d3_upd_valid", 32'(bus.upd_valid), 32'd1);
            chk("d3_upd_tag", bus.upd_tag, 32'h1000 + 32'(i * 4));
        end
        chk("d3_empty", 32'(bus.occupancy), 32'd0);
        idle(1);

        // Update stalled by the predictor
        cyc(1, 32'h500, 1, 32'h600, 5'd7, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h600, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("d4_res_ready", 32'(bus.res_ready), 32'd0);
            chk("d4_upd_tag", bus.upd_tag, 32'h500);
            chk("d4_upd_index", 32'(bus.upd_index), 32'd7);
            idle(0);
        end
        idle(1);
        chk("d4_idle", 32'(bus.upd_valid), 32'd0);

        // Underflow
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h123, 1, 0);
        chk("d5_err", 32'(bus.err_underflow), 32'd1);
        chk("d5_no_upd", 32'(bus.upd_valid), 32'd0);

        // Reset while updating with entries queued
        for (int i = 0; i < 3; i++)
            cyc(1, 32'h700 + 32'(i * 4), 0, 0, 5'd2, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("d6_pre_occ", 32'(bus.occupancy), 32'd2);
        cyc(1, 32'h900, 0, 0, 0, 1, 0, 0, 0, 1);
        chk("d6_upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("d6_occupancy", 32'(bus.occupancy), 32'd0);
        chk("d6_mcnt", 32'(bus.mispredict_cnt), 32'd0);
        chk("d6_err", 32'(bus.err_underflow), 32'd0);
        chk("d6_res_ready", 32'(bus.res_ready), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rs   = ($urandom_range(0, 299) == 0);
            pv   = ($urandom_range(0, 99) < 55);
            pc   = 32'h1000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            pt   = 1'($urandom_range(0, 1));
            ptg  = 32'h200 + 32'($urandom_range(0, 2)) * 32'h100;
            pidx = IDX_W'($urandom_range(0, 31));
            rv   = ($urandom_range(0, 99) < 50);
            ur   = ($urandom_range(0, 99) < 70);
            rt   = 1'($urandom_range(0, 1));
            rtg  = 32'h200 + 32'($urandom_range(0, 2)) * 32'h100;
            if (q.size() != 0 && $urandom_range(0, 99) < 80) begin
                rt  = q[0].taken;
                rtg = q[0].taken ? q[0].target : rtg;
            end
            cyc(pv, pc, pt, ptg, pidx, rv, rt, rtg, ur, rs);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/branch_update_ctrl.md
BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the in-flight branch queue depth (power of two, 2..8).
REQ-002 SHALL have parameter IDX_W, default 5, giving the predictor table index width.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pred_valid, input, 1 bit: fetch allocates a predicted control instruction.
REQ-006 SHALL have ports pred_pc (input, 32), pred_taken (input, 1), pred_target (input, 32) and pred_idx (input, IDX_W): the prediction snapshot.
REQ-007 SHALL have port alloc_ready, output, 1 bit: queue not full.
REQ-008 SHALL have port res_valid, input, 1 bit: execute resolves the oldest in-flight branch (in order).
REQ-009 SHALL have ports res_taken (input, 1) and res_target (input, 32): the actual outcome.
REQ-010 SHALL have port res_ready, output, 1 bit: resolution accepted this cycle.
REQ-011 SHALL have ports upd_valid (output, 1), upd_index (output, IDX_W), upd_tag (output, 32), upd_target (output, 32) and upd_taken (output, 1): the predictor write request.
REQ-012 SHALL have port upd_ready, input, 1 bit: the predictor accepts the write.
REQ-013 SHALL have ports flush (output, 1) and redirect_pc (output, 32): the pipeline redirect.
REQ-014 SHALL have ports occupancy (output, clog2(DEPTH)+1), mispredict_cnt (output, 16) and err_underflow (output, 1).

Function
REQ-015 SHALL implement a circular FIFO of DEPTH entries {pc, taken, target, idx}, with head and tail pointers that wrap modulo DEPTH.
REQ-016 SHALL drive alloc_ready = (occupancy != DEPTH), combinationally from the registered count.
REQ-017 SHALL write the snapshot at the tail on a cycle with pred_valid && alloc_ready, and SHALL ignore pred_valid when alloc_ready is 0.
REQ-018 SHALL drive res_ready = !upd_valid || upd_ready.
REQ-019 SHALL accept a resolution on a cycle with res_valid && res_ready && occupancy != 0, and SHALL pop the head on that cycle.
REQ-020 SHALL ignore res_valid when occupancy == 0 and SHALL set err_underflow (sticky until reset).
REQ-021 SHALL classify an accepted resolution as a mispredict when head.taken != res_taken, or when res_taken && head.target != res_target.
REQ-022 SHALL form the update register as a 2-state FSM with states IDLE and UPD.
REQ-023 SHALL, on an accepted resolution, load upd_index = head.idx, upd_tag = head.pc, upd_target = res_target and upd_taken = res_taken, and SHALL enter UPD with upd_valid = 1 one cycle after acceptance.
REQ-024 SHALL hold all upd_* outputs stable in UPD until upd_ready = 1.
REQ-025 SHALL, on UPD && upd_ready with no new acceptance, return to IDLE.
REQ-026 SHALL, on UPD && upd_ready with a same-cycle acceptance, reload the update register and remain in UPD (back-to-back, one update per cycle).
REQ-027 SHALL, on a mispredict, assert flush for exactly one cycle one cycle after acceptance.
REQ-028 SHALL set redirect_pc to res_target if res_taken, else head.pc + 4 (32-bit wrap), valid while flush = 1.
REQ-029 SHALL, on a mispredict, discard all queue entries on the accepting edge (occupancy becomes 0), and SHALL drop any same-cycle allocation.
REQ-030 SHALL, on a simultaneous allocation and correct-prediction pop, leave occupancy unchanged, with the entry written at the tail.
REQ-031 SHALL hold redirect_pc at its last value when flush = 0.
REQ-032 SHALL increment mispredict_cnt by 1 per mispredict, saturating at 16'hFFFF.

Reset
REQ-033 SHALL, while reset = 1 at a clock edge, clear head, tail and occupancy to 0, set the FSM to IDLE, and set upd_valid, flush and err_underflow to 0.
REQ-034 SHALL, while reset = 1 at a clock edge, set mispredict_cnt to 0 and upd_index, upd_tag, upd_target, upd_taken and redirect_pc to 0.
REQ-035 SHALL, when reset is asserted mid-operation, drop any pending update and queued entries without issuing them, giving alloc_ready = 1 and res_ready = 1 the cycle after reset.
REQ-036 SHALL ignore pred_valid and res_valid while reset = 1.

Verification
REQ-037 SHALL be verified with: allocate pc 0x100 (taken, target 0x200, idx 3), resolve taken/0x200 -> next cycle upd_valid = 1, idx 3, tag 0x100, target 0x200, flush = 0.
REQ-038 SHALL be verified with: allocate pc 0x40 (not taken), resolve taken/0x80 -> flush pulse one cycle, redirect_pc = 0x80, occupancy 0, mispredict_cnt 1.
REQ-039 SHALL be verified with: allocate 4 entries (DEPTH = 4) -> alloc_ready = 0, a fifth pred_valid is dropped; resolve 4 in order with upd_ready = 1 -> four consecutive updates in FIFO order, with a pointer wrap exercised.
REQ-040 SHALL be verified with: upd_ready held 0 for 3 cycles after a resolution -> res_ready = 0 and upd_* stable for those cycles; upd_ready = 1 -> IDLE.
REQ-041 SHALL be verified with: res_valid with an empty queue -> no update, err_underflow = 1.
REQ-042 SHALL be verified with: reset asserted while in UPD with 2 entries queued -> after reset upd_valid = 0, occupancy 0 and mispredict_cnt 0.
